seg_controller_int: RTL and testbench

//  8-digit multiplexed seven-segment display driver for the temperature alarm

---
 rtl/seg_controller_int.sv | 72 +++++++
 tb/tb_seg_controller_int.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg_controller_int.sv
// Eight-digit multiplexed seven-segment driver: scans one hex nibble per slot
// and drives active-low anodes and cathodes from registered outputs.
module seg_controller_int #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Seg_Display,
   output logic [7:0]  AN,
   output logic [6:0]  Digits_Bits
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] div_cnt_r;
   logic [2:0]       idx_r;
   logic             slot_end_s;
   logic [3:0]       nibble_s;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         4'hF:    seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   // Slot-end detect and live selection of the current digit's nibble.
   always_comb begin
      slot_end_s = (div_cnt_r == CNT_LAST);
      nibble_s   = Seg_Display[{idx_r, 2'b00} +: 4];
   end

   // Slot divider, digit index and registered display outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div_cnt_r   <= '0;
         idx_r       <= 3'd0;
         AN          <= 8'hFF;
         Digits_Bits <= 7'h7F;
      end else begin
         if (slot_end_s) begin
            div_cnt_r <= '0;
            idx_r     <= idx_r + 3'd1;
         end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
            idx_r     <= idx_r;
         end
         // Outputs follow the index held before this edge's update.
         AN          <= ~(8'b0000_0001 << idx_r);
         Digits_Bits <= hex_to_seg(nibble_s);
      end
   end

endmodule

// File: tb/tb_seg_controller_int.sv
// Bench for seg_controller_int: directed scan sequences plus randomized display
// values checked against an edge-count reference model, at SCAN_DIV 2 and 1.
module tb_seg_controller_int;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sd;
   logic [7:0]  an2, an1;
   logic [6:0]  seg2, seg1;

   int n_pass   = 0;
   int n_checks = 0;

   localparam logic [6:0] HEX_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   localparam logic [6:0] T3 [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
   localparam logic [6:0] T6 [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

   seg_controller_int #(.SCAN_DIV(2)) dut2 (
      .Clk(clk), .Reset(rst), .Seg_Display(sd), .AN(an2), .Digits_Bits(seg2));
   seg_controller_int #(.SCAN_DIV(1)) dut1 (
      .Clk(clk), .Reset(rst), .Seg_Display(sd), .AN(an1), .Digits_Bits(seg1));

   always #5 clk = ~clk;

   function automatic logic [7:0] an_of(input int k);
      return 8'hFF ^ (8'd1 << k);
   endfunction

   function automatic logic [6:0] seg_of(input logic [31:0] v, input int k);
      logic [31:0] nib;
      nib = (v >> (4 * k)) & 32'hF;
      return HEX_TBL[nib[3:0]];
   endfunction

   // Reference model: edge e after reset shows digit (e / SCAN_DIV) mod 8.
   int          m_edges;
   logic [7:0]  m_an2, m_an1;
   logic [6:0]  m_seg2, m_seg1;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edges <= 0;
         m_an2   <= 8'hFF;
         m_an1   <= 8'hFF;
         m_seg2  <= 7'h7F;
         m_seg1  <= 7'h7F;
      end else begin
         m_edges <= m_edges + 1;
         m_an2   <= an_of((m_edges / 2) % 8);
         m_seg2  <= seg_of(sd, (m_edges / 2) % 8);
         m_an1   <= an_of(m_edges % 8);
         m_seg1  <= seg_of(sd, m_edges % 8);
      end
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_blank(input string tag);
      check({tag, "_an2"},  an2, 8'hFF);
      check({tag, "_seg2"}, {1'b0, seg2}, 8'h7F);
      check({tag, "_an1"},  an1, 8'hFF);
      check({tag, "_seg1"}, {1'b0, seg1}, 8'h7F);
   endtask

   task automatic model_check(input string tag);
      check({tag, "_m_an2"},  an2, m_an2);
      check({tag, "_m_seg2"}, {1'b0, seg2}, {1'b0, m_seg2});
      check({tag, "_m_an1"},  an1, m_an1);
      check({tag, "_m_seg1"}, {1'b0, seg1}, {1'b0, m_seg1});
      check({tag, "_onecold2"}, 8'($countones(~an2)), 8'd1);
      check({tag, "_onecold1"}, 8'($countones(~an1)), 8'd1);
   endtask

   initial begin
      int k;
      // Reset visible before any clock edge, and held across edges.
      rst = 1'b1;
      sd  = 32'h0000_0032;
      #1;
      check_blank("rst_pre_edge");
      @(negedge clk);
      check_blank("rst_held");
      @(negedge clk);
      rst = 1'b0;

      // Full frame of 32'h32 at SCAN_DIV=2, then wrap to digit 0.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         k = (i / 2) % 8;
         check("t2_an", an2, an_of(k));
         check("t2_seg", {1'b0, seg2}, (k == 0) ? 8'h24 : (k == 1) ? 8'h30 : 8'h40);
         model_check("t2");
      end

      // Mid-slot change on digit 0: segments follow next edge, slot timing intact.
      sd = 32'h0000_0000;
      @(negedge clk);
      check("t4_an_same", an2, 8'hFE);
      check("t4_seg", {1'b0, seg2}, 8'h40);
      @(negedge clk);
      check("t4_an_next", an2, 8'hFD);
      model_check("t4");

      // Advance to digit 5, then reset asynchronously between edges.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         model_check("pre_t5");
      end
      check("t5_idx5_an", an2, 8'hDF);
      #2;
      rst = 1'b1;
      #1;
      check_blank("t5_async");
      @(negedge clk);
      check_blank("t5_hold");
      sd  = 32'h89AB_CDEF;
      rst = 1'b0;

      // Hex letters across a full frame after the restart.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("t3_an", an2, an_of(i / 2));
         check("t3_seg", {1'b0, seg2}, {1'b0, T3[i / 2]});
         model_check("t3");
      end

      // SCAN_DIV=1 rotation every cycle.
      rst = 1'b1;
      sd  = 32'h7654_3210;
      #1;
      check_blank("t6_rst");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("t6_an", an1, an_of(i % 8));
         check("t6_seg", {1'b0, seg1}, {1'b0, T6[i % 8]});
         model_check("t6");
      end

      // Random display values changed every cycle, with one reset pulse.
      for (int i = 0; i < 300; i++) begin
         sd = $urandom;
         if (i == 150) begin
            rst = 1'b1;
            #1;
            check_blank("rand_rst");
            @(negedge clk);
            rst = 1'b0;
         end
         @(negedge clk);
         model_check("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
